feature_frame_loader: RTL

Double-buffered input feature store that feeds the Q8.8 classifier core. It accepts one keyword-spotting feature frame of N_FEAT Q8.8 words over a valid/ready stream into a write bank. It then swaps banks and drives the core's level-sensitive `start` / `valid` handshake. While the core runs, it serves the core's feature read port from the read bank, in place of the fixed test-input ROM.

---
 rtl/feature_frame_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/feature_frame_loader.sv
// Double-buffered Q8.8 feature store: loads one frame from a valid/ready stream
// into the write bank, then swaps banks and runs the classifier core's start/valid handshake.
`timescale 1ns/1ps
module feature_frame_loader #(
  parameter int N_FEAT = 1274,
  parameter int DW     = 16,
  parameter int AW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [AW-1:0] rd_index,
  output logic [DW-1:0] rd_data,
  output logic          nn_start,
  input  logic          nn_valid,
  output logic          frame_err,
  output logic [7:0]    frames_done
);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} ns_t;

  ns_t           ns, ns_next;
  logic [DW-1:0] bank0 [N_FEAT];
  logic [DW-1:0] bank1 [N_FEAT];
  logic          rd_bank;
  logic [AW-1:0] wcnt;
  logic          pend_full;
  logic          drop;
  logic          accept;
  logic          at_end;
  logic          swap;
  logic          start_next;
  logic          done_inc;

  assign s_ready = ~pend_full & ~rst;
  assign accept  = s_valid & s_ready;
  assign at_end  = (wcnt == AW'(N_FEAT - 1));

  // Words land in the bank the core is not reading; dropped words are discarded.
  always_ff @(posedge clk) begin
    if (accept && !drop) begin
      if (rd_bank) bank0[wcnt] <= s_data;
      else         bank1[wcnt] <= s_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_index) < N_FEAT) begin
      rd_data = rd_bank ? bank1[rd_index] : bank0[rd_index];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      pend_full <= 1'b0;
      drop      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (swap) pend_full <= 1'b0;
      // A frame is valid only if s_last lands exactly on word N_FEAT-1.
      if (accept) begin
        if (drop) begin
          if (s_last) drop <= 1'b0;
        end else if (s_last) begin
          wcnt <= '0;
          if (at_end) pend_full <= 1'b1;
          else        frame_err <= 1'b1;
        end else if (at_end) begin
          wcnt      <= '0;
          frame_err <= 1'b1;
          drop      <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ns          <= IDLE;
      nn_start    <= 1'b0;
      rd_bank     <= 1'b0;
      frames_done <= 8'd0;
    end else begin
      ns       <= ns_next;
      nn_start <= start_next;
      if (swap)     rd_bank     <= ~rd_bank;
      if (done_inc) frames_done <= frames_done + 8'd1;
    end
  end

  // Swapping only from IDLE keeps the read bank frozen for a whole inference
  // and guarantees start is never raised while the core still shows valid.
  always_comb begin
    ns_next    = ns;
    start_next = nn_start;
    swap       = 1'b0;
    done_inc   = 1'b0;
    case (ns)
      IDLE: begin
        if (pend_full) begin
          swap       = 1'b1;
          start_next = 1'b1;
          ns_next    = RUN;
        end
      end
      RUN: begin
        start_next = 1'b1;
        if (nn_valid) begin
          start_next = 1'b0;
          ns_next    = RELEASE;
        end
      end
      RELEASE: begin
        if (!nn_valid) begin
          done_inc = 1'b1;
          ns_next  = IDLE;
        end
      end
      default: ns_next = IDLE;
    endcase
  end

endmodule
